id_stage_ctrl: RTL
==================

Name: id_stage_ctrl

Overview:
- Decode-stage controller for the MIPS pipeline.
- Owns the IF/ID pipeline register and the fetch/decode valid-ready handshake.
- Classifies each instruction's immediate as signed or unsigned and drives the select flag of the sign-extension unit.
- Inserts load-use stall bubbles, flushes on a taken branch, stops the front end on HALT, and counts stall cycles for debug.

Parameters:
- NB_DATA, 32, instruction/data width.
- NB_IMM, 16, immediate field width.
- NB_REG, 5, register-address width.
- NB_CNT, 16, stall-counter width (saturating).

Ports:
- i_clk  in  1  system clock, rising edge.
- i_rst_n  in  1  reset, asynchronous, active-low.
- i_if_valid  in  1  fetch stage presents a valid instruction.
- i_if_instr  in  NB_DATA  fetched instruction.
- o_if_ready  out  1  controller accepts the fetched instruction this cycle.
- i_ex_mem_read  in  1  the instruction in EX is a load.
- i_ex_rt  in  NB_REG  destination register of the load in EX.
- i_branch_taken  in  1  EX resolved a taken branch or jump; flush the younger instruction.
- o_id_valid  out  1  ID holds a valid, non-bubble instruction.
- o_id_instr  out  NB_DATA  registered instruction.
- o_imm_value  out  NB_IMM  o_id_instr[15:0].
- o_imm_signed  out  1  select flag for the sign-extension unit: 1 = sign-extend, 0 = zero-extend.
- o_id_ex_bubble  out  1  force the ID/EX control word to NOP this cycle.
- o_halted  out  1  HALT reached ID; front end frozen.
- o_stall_cnt  out  NB_CNT  saturating count of load-use stall cycles.

Behaviour:
- Reset (async assert, sync release): state=RUN, o_id_valid=0, o_id_instr=0, o_imm_signed=0, o_id_ex_bubble=0, o_halted=0, o_stall_cnt=0, o_if_ready=0 while reset is asserted.
- States:
  - RUN: o_if_ready=1; on i_if_valid, IF/ID captures i_if_instr next edge with o_id_valid=1; if i_if_valid=0, o_id_valid goes 0 next edge.
  - STALL: exactly one cycle.
    - Entered from RUN when o_id_valid and i_ex_mem_read and i_ex_rt!=0 and i_ex_rt equals rs [25:21], or equals rt [20:16] for R-type, store or branch.
    - Combinationally in the detect cycle: o_if_ready=0, o_id_ex_bubble=1, IF/ID held.
    - The controller spends one cycle in STALL, then returns to RUN; the hazard re-evaluates with the new EX contents.
  - FLUSH: entered on i_branch_taken from RUN or STALL.
    - Next edge: o_id_valid=0, o_id_instr=0.
    - Fetch is accepted that same cycle only if the fetch stage has redirected (i_if_valid is taken at face value).
    - Returns to RUN after one cycle.
  - HALTED: entered when o_id_valid and opcode[31:26]=6'b111111.
    - o_if_ready=0 and o_halted=1; the HALT instruction is forwarded once to EX.
    - Held until reset; i_branch_taken is ignored.
- Priority when events coincide: reset > i_branch_taken > load-use stall > HALT > normal fetch. A flush cancels a simultaneously detected stall; the stall counter does not increment.
- Immediate classification from o_id_instr opcode, combinational, registered-path latency 0 relative to o_id_instr:
  - signed=1: 001000 ADDI, 001001 ADDIU, 001010 SLTI, 001011 SLTIU, 000100 BEQ, 000101 BNE, 10xxxx loads/stores.
  - signed=0: 001100 ANDI, 001101 ORI, 001110 XORI, 001111 LUI, 000000 R-type, and all others.
  - o_imm_signed is forced to 0 when o_id_valid=0.
- o_stall_cnt increments by 1 per STALL-entry cycle and saturates at 2^NB_CNT-1; it does not wrap.
- Reset asserted mid-stall or mid-flush returns to RUN with all outputs at their reset values immediately; the in-flight instruction is lost.

Decomposition:
- Shared package mips_pkg: opcode localparams (OP_RTYPE, OP_ADDI … OP_LUI, OP_HALT, load/store masks) and the state encoding (RUN, STALL, FLUSH, HALTED, 2 bits).
- Sub-module imm_class_decoder: combinational opcode-to-o_imm_signed table, reused by the debug unit.
- Hazard compare, FSM and IF/ID register stay in id_stage_ctrl.

Test Plan:
- Reset then ADDI r1,r0,0xFFFC (0x2001FFFC) with i_if_valid=1 -> next cycle o_id_valid=1, o_imm_value=0xFFFC, o_imm_signed=1.
- ORI 0x3421FFFC -> o_imm_signed=0. LUI 0x3C01FFFC -> o_imm_signed=0. BEQ 0x1022FFFE -> o_imm_signed=1.
- ID=ADD r3,r1,r2 (0x00221820), i_ex_mem_read=1, i_ex_rt=2 -> one cycle with o_if_ready=0 and o_id_ex_bubble=1, o_stall_cnt 0->1, ID unchanged; same scenario with i_ex_rt=0 -> no stall.
- Load-use stall and i_branch_taken in the same cycle -> flush wins: o_id_valid=0 next cycle, o_stall_cnt unchanged, state RUN after one cycle.
- HALT 0xFC000000 reaches ID -> o_halted=1 and o_if_ready=0, held for 20 cycles despite i_branch_taken pulses; i_rst_n low clears o_halted asynchronously.
- NB_CNT=2, four back-to-back load-use hazards -> o_stall_cnt stops at 3.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS decode constants: opcodes, memory-op masks and the
// decode-stage controller state encoding.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_SLTIU = 6'b001011;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_HALT  = 6'b111111;

    // Loads are 100xxx and stores are 101xxx.
    localparam logic [5:0] OP_MEM_MASK    = 6'b110000;
    localparam logic [5:0] OP_MEM_MATCH   = 6'b100000;
    localparam logic [5:0] OP_STORE_MASK  = 6'b111000;
    localparam logic [5:0] OP_STORE_MATCH = 6'b101000;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        STALL  = 2'd1,
        FLUSH  = 2'd2,
        HALTED = 2'd3
    } id_state_e;

    function automatic logic is_mem_op(input logic [5:0] op);
        return (op & OP_MEM_MASK) == OP_MEM_MATCH;
    endfunction

    function automatic logic is_store_op(input logic [5:0] op);
        return (op & OP_STORE_MASK) == OP_STORE_MATCH;
    endfunction

endpackage

// File: rtl/imm_class_decoder.sv
// Opcode-to-extension-mode table for the 16-bit immediate field.
// Arithmetic, compare, branch and memory offsets are sign-extended;
// logical immediates, LUI, R-type and anything unknown are zero-extended.
module imm_class_decoder
    import mips_pkg::*;
(
    input  logic [5:0] i_opcode,
    output logic       o_imm_signed
);

    // Combinational classification; unknown opcodes fall back to zero-extend.
    always_comb begin
        o_imm_signed = 1'b0;
        case (i_opcode)
            OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU,
            OP_BEQ, OP_BNE:                          o_imm_signed = 1'b1;
            OP_ANDI, OP_ORI, OP_XORI, OP_LUI,
            OP_RTYPE:                                o_imm_signed = 1'b0;
            default:                                 o_imm_signed = is_mem_op(i_opcode);
        endcase
    end

endmodule

// File: rtl/id_stage_ctrl.sv
// Decode-stage controller: IF/ID register, fetch handshake, load-use
// stall, branch flush, HALT freeze and a saturating stall counter.
//
//   state  | meaning
//   RUN    | normal fetch/decode, hazards and HALT evaluated
//   STALL  | one cycle after a load-use bubble; fetch resumes
//   FLUSH  | IF/ID cleared by a taken branch; redirected fetch accepted
//   HALTED | HALT reached ID; front end frozen until reset
module id_stage_ctrl
    import mips_pkg::*;
#(
    parameter int NB_DATA = 32,
    parameter int NB_IMM  = 16,
    parameter int NB_REG  = 5,
    parameter int NB_CNT  = 16
)(
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_if_valid,
    input  logic [NB_DATA-1:0] i_if_instr,
    output logic               o_if_ready,
    input  logic               i_ex_mem_read,
    input  logic [NB_REG-1:0]  i_ex_rt,
    input  logic               i_branch_taken,
    output logic               o_id_valid,
    output logic [NB_DATA-1:0] o_id_instr,
    output logic [NB_IMM-1:0]  o_imm_value,
    output logic               o_imm_signed,
    output logic               o_id_ex_bubble,
    output logic               o_halted,
    output logic [NB_CNT-1:0]  o_stall_cnt
);

    id_state_e          r_state;
    logic               r_id_valid;
    logic [NB_DATA-1:0] r_id_instr;
    logic               r_halted;
    logic [NB_CNT-1:0]  r_stall_cnt;

    logic [5:0]         w_opcode;
    logic [NB_REG-1:0]  w_rs;
    logic [NB_REG-1:0]  w_rt;
    logic               w_uses_rt;
    logic               w_hazard;
    logic               w_flush_req;
    logic               w_stall_go;
    logic               w_halt_go;
    logic               w_dec_signed;

    assign w_opcode = r_id_instr[31:26];
    assign w_rs     = r_id_instr[25:21];
    assign w_rt     = r_id_instr[20:16];

    // rt is a source only for R-type, stores and two-register branches.
    assign w_uses_rt = (w_opcode == OP_RTYPE) || is_store_op(w_opcode) ||
                       (w_opcode == OP_BEQ)   || (w_opcode == OP_BNE);

    // Hazards are only evaluated in RUN, so each stall lasts exactly one cycle.
    assign w_hazard = (r_state == RUN) && r_id_valid && i_ex_mem_read &&
                      (i_ex_rt != '0) &&
                      ((i_ex_rt == w_rs) || (w_uses_rt && (i_ex_rt == w_rt)));

    assign w_flush_req = i_branch_taken && (r_state != HALTED);
    assign w_stall_go  = w_hazard && !w_flush_req;
    assign w_halt_go   = ((r_state == RUN) || (r_state == STALL)) && r_id_valid &&
                         (w_opcode == OP_HALT) && !w_flush_req && !w_hazard;

    // A fetch is only accepted when the IF/ID register will actually load it.
    assign o_if_ready = i_rst_n && (r_state != HALTED) &&
                        !w_flush_req && !w_stall_go && !w_halt_go;

    assign o_id_ex_bubble = w_stall_go;
    assign o_id_valid     = r_id_valid;
    assign o_id_instr     = r_id_instr;
    assign o_imm_value    = r_id_instr[NB_IMM-1:0];
    assign o_halted       = r_halted;
    assign o_stall_cnt    = r_stall_cnt;

    imm_class_decoder u_imm_class (
        .i_opcode     (w_opcode),
        .o_imm_signed (w_dec_signed)
    );

    assign o_imm_signed = r_id_valid && w_dec_signed;

    // FSM, IF/ID register and stall counter; priority flush > stall > HALT > fetch.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= RUN;
            r_id_valid  <= 1'b0;
            r_id_instr  <= '0;
            r_halted    <= 1'b0;
            r_stall_cnt <= '0;
        end else if (w_flush_req) begin
            r_state    <= FLUSH;
            r_id_valid <= 1'b0;
            r_id_instr <= '0;
        end else if (w_stall_go) begin
            r_state <= STALL;
            if (r_stall_cnt != {NB_CNT{1'b1}})
                r_stall_cnt <= r_stall_cnt + NB_CNT'(1);
        end else if (w_halt_go) begin
            r_state    <= HALTED;
            r_id_valid <= 1'b0;
            r_halted   <= 1'b1;
        end else if (r_state != HALTED) begin
            r_state    <= RUN;
            r_id_valid <= i_if_valid;
            if (i_if_valid)
                r_id_instr <= i_if_instr;
        end
    end

endmodule
